// File: rtl/aho_pkg.sv
// Shared defaults and types for the Aho-Corasick output-state matcher.
package aho_pkg;

    localparam int DEF_STATE_W = 8;
    localparam int DEF_NUM_OUT = 32;
    localparam int DEF_ID_W    = $clog2(DEF_NUM_OUT);
    localparam int DEF_CNT_W   = 16;

    typedef logic [DEF_STATE_W-1:0] state_t;
    typedef logic [DEF_ID_W-1:0]    out_id_t;

    localparam state_t ROOT_STATE = '0;

endpackage

// File: rtl/aho_prio_enc.sv
// Lowest-index-wins priority encoder: NUM_OUT hit bits -> index plus any-hit.
module aho_prio_enc
    import aho_pkg::*;
#(
    parameter int NUM_OUT = DEF_NUM_OUT,
    parameter int ID_W    = DEF_ID_W
) (
    input  logic [NUM_OUT-1:0] hits,
    output logic [ID_W-1:0]    id,
    output logic               any
);

    // NOTE: every output gets a default before the loop, so no latch is inferred.
    always_comb begin
        id  = '0;
        any = |hits;
        // Scan downwards so the lowest set bit is the last (winning) assignment.
        for (int i = NUM_OUT - 1; i >= 0; i--) begin
            if (hits[i]) begin
                id = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/aho_output_matcher.sv
// Two-stage matcher of automaton states against a writable accepting-state table.
// Optional AHO_MATCH_COUNT_EN adds a saturating delivered-match counter.
module aho_output_matcher
    import aho_pkg::*;
#(
    parameter int STATE_W = DEF_STATE_W,
    parameter int NUM_OUT = DEF_NUM_OUT,
    parameter int ID_W    = DEF_ID_W,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic               CLK,
    input  logic               INITIALIZE,
    input  logic               EN,
    input  logic [STATE_W-1:0] STATE_DATA,
    output logic               IN_READY,
    input  logic               WR_EN,
    input  logic [ID_W-1:0]    WR_ADDR,
    input  logic [STATE_W-1:0] WR_STATE,
    input  logic               WR_VALID,
    output logic               OUT_VALID,
    input  logic               OUT_READY,
    output logic               MATCH,
    output logic [ID_W-1:0]    MATCH_ID,
    output logic               MATCH_FLAG,
    output logic [CNT_W-1:0]   MATCH_COUNT
);

    logic [STATE_W-1:0] entry_state [NUM_OUT];
    logic [NUM_OUT-1:0] entry_valid;
    logic [NUM_OUT-1:0] hits;
    logic               wr_ok;

    logic               s1_valid;
    logic [NUM_OUT-1:0] s1_hits;
    logic               s2_valid;
    logic               s2_match;
    logic [ID_W-1:0]    s2_id;
    logic               match_flag;
    logic [ID_W-1:0]    enc_id;
    logic               enc_any;
    logic               advance;
    logic               deliver;

    assign wr_ok = WR_EN && (int'(WR_ADDR) < NUM_OUT);

    always_ff @(posedge CLK) begin
        if (INITIALIZE) begin
            entry_valid <= '0;
        end else if (wr_ok) begin
            entry_valid[WR_ADDR] <= WR_VALID;
        end
    end

    // NOTE: the state array has no reset; a cleared valid bit makes its contents irrelevant.
    always_ff @(posedge CLK) begin
        if (!INITIALIZE && wr_ok) begin
            entry_state[WR_ADDR] <= WR_STATE;
        end
    end

    always_comb begin
        hits = '0;
        for (int i = 0; i < NUM_OUT; i++) begin
            hits[i] = entry_valid[i] && (entry_state[i] == STATE_DATA);
        end
    end

    // A held result blocks both stages, so the pipeline stalls as one unit.
    assign advance  = !(s2_valid && !OUT_READY);
    assign IN_READY = advance;
    assign deliver  = s2_valid && OUT_READY;

    aho_prio_enc #(
        .NUM_OUT (NUM_OUT),
        .ID_W    (ID_W)
    ) u_prio_enc (
        .hits (s1_hits),
        .id   (enc_id),
        .any  (enc_any)
    );

    // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (INITIALIZE) begin
            s1_valid <= 1'b0;
            s1_hits  <= '0;
            s2_valid <= 1'b0;
            s2_match <= 1'b0;
            s2_id    <= '0;
        end else if (advance) begin
            s1_valid <= EN;
            s1_hits  <= EN ? hits : '0;
            s2_valid <= s1_valid;
            s2_match <= s1_valid && enc_any;
            s2_id    <= (s1_valid && enc_any) ? enc_id : '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (INITIALIZE) begin
            match_flag <= 1'b0;
        end else if (deliver && s2_match) begin
            match_flag <= 1'b1;
        end
    end

`ifdef AHO_MATCH_COUNT_EN
    logic [CNT_W-1:0] match_count;

    always_ff @(posedge CLK) begin
        if (INITIALIZE) begin
            match_count <= '0;
        end else if (deliver && s2_match && (match_count != '1)) begin
            match_count <= match_count + 1'b1;
        end
    end

    assign MATCH_COUNT = match_count;
`else
    assign MATCH_COUNT = '0;
`endif

    assign OUT_VALID  = s2_valid;
    assign MATCH      = s2_match;
    assign MATCH_ID   = s2_id;
    assign MATCH_FLAG = match_flag;

endmodule

// File: tb/tb_aho_output_matcher.sv
// Randomized and directed bench for aho_output_matcher against a queue-based reference model.
module tb_aho_output_matcher;
    import aho_pkg::*;

    localparam int STATE_W = 8;
    localparam int NUM_OUT = 32;
    localparam int ID_W    = 5;
`ifdef AHO_MATCH_COUNT_EN
    localparam int CNT_W   = 2;
`else
    localparam int CNT_W   = 16;
`endif

    logic               clk = 1'b0;
    logic               initialize = 1'b1;
    logic               en = 1'b0;
    logic [STATE_W-1:0] state_data = '0;
    logic               in_ready;
    logic               wr_en = 1'b0;
    logic [ID_W-1:0]    wr_addr = '0;
    logic [STATE_W-1:0] wr_state = '0;
    logic               wr_valid = 1'b0;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic               match;
    logic [ID_W-1:0]    match_id;
    logic               match_flag;
    logic [CNT_W-1:0]   match_count;

    aho_output_matcher #(
        .STATE_W (STATE_W),
        .NUM_OUT (NUM_OUT),
        .ID_W    (ID_W),
        .CNT_W   (CNT_W)
    ) dut (
        .CLK         (clk),
        .INITIALIZE  (initialize),
        .EN          (en),
        .STATE_DATA  (state_data),
        .IN_READY    (in_ready),
        .WR_EN       (wr_en),
        .WR_ADDR     (wr_addr),
        .WR_STATE    (wr_state),
        .WR_VALID    (wr_valid),
        .OUT_VALID   (out_valid),
        .OUT_READY   (out_ready),
        .MATCH       (match),
        .MATCH_ID    (match_id),
        .MATCH_FLAG  (match_flag),
        .MATCH_COUNT (match_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit m;
        int id;
        int acc;
    } res_t;

    // Reference model: the table as plain arrays, in-flight results as an ordered queue.
    int   m_state [NUM_OUT];
    bit   m_valid [NUM_OUT];
    res_t pend [$];
    res_t got [$];
    bit   m_flag;
    int   m_count;
    int   cyc;
    int   n_cmp;
    int   n_bad;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic res_t lookup(input int s);
        res_t r;
        r.m   = 1'b0;
        r.id  = 0;
        r.acc = 0;
        for (int i = 0; i < NUM_OUT; i++) begin
            if (m_valid[i] && m_state[i] == s) begin
                r.m  = 1'b1;
                r.id = i;
                break;
            end
        end
        return r;
    endfunction

    // One clock: inputs are already driven; check, update model, take the edge, check sticky state.
    task automatic step();
        bit   exp_ov;
        bit   was_init;
        res_t r;
        #1;
        was_init = initialize;
        if (!initialize) begin
            exp_ov = (pend.size() > 0) && (cyc >= pend[0].acc + 2);
            check("out_valid", 32'(out_valid), 32'(exp_ov));
            if (out_valid && pend.size() > 0) begin
                check("match", 32'(match), 32'(pend[0].m));
                check("match_id", 32'(match_id), 32'(pend[0].id));
            end
            check("in_ready", 32'(in_ready), 32'(!(exp_ov && !out_ready)));
            if (exp_ov && out_ready) begin
                r = pend.pop_front();
                got.push_back(r);
                if (r.m) begin
                    m_flag = 1'b1;
                    if (m_count < (1 << CNT_W) - 1) m_count++;
                end
            end
            if (en && !(exp_ov && !out_ready)) begin
                r = lookup(int'(state_data));
                r.acc = cyc;
                pend.push_back(r);
            end
            if (wr_en && int'(wr_addr) < NUM_OUT) begin
                m_state[wr_addr] = int'(wr_state);
                m_valid[wr_addr] = wr_valid;
            end
        end else begin
            pend.delete();
            for (int i = 0; i < NUM_OUT; i++) m_valid[i] = 1'b0;
            m_flag  = 1'b0;
            m_count = 0;
        end
        @(posedge clk);
        cyc++;
        #1;
        check("match_flag", 32'(match_flag), 32'(m_flag));
`ifdef AHO_MATCH_COUNT_EN
        check("match_count", 32'(match_count), 32'(m_count));
`else
        check("match_count_tied", 32'(match_count), 32'd0);
`endif
        if (was_init) begin
            check("rst_out_valid", 32'(out_valid), 32'd0);
            check("rst_match", 32'(match), 32'd0);
            check("rst_match_id", 32'(match_id), 32'd0);
        end
        @(negedge clk);
    endtask

    task automatic idle();
        en = 1'b0;
        wr_en = 1'b0;
        initialize = 1'b0;
    endtask

    task automatic drain();
        idle();
        out_ready = 1'b1;
        for (int i = 0; i < 40 && pend.size() > 0; i++) step();
        check("drain_empty", 32'(pend.size()), 32'd0);
        step();
    endtask

    task automatic write(input int a, input int s, input bit v);
        wr_en = 1'b1;
        wr_addr = ID_W'(a);
        wr_state = STATE_W'(s);
        wr_valid = v;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        cyc = 0;
        m_flag = 1'b0;
        m_count = 0;
        for (int i = 0; i < NUM_OUT; i++) begin
            m_valid[i] = 1'b0;
            m_state[i] = 0;
        end
        @(negedge clk);
        initialize = 1'b1;
        step();
        step();
        idle();

        // Basic match with duplicate entries: lowest index reported.
        write(3, 'h12, 1'b1); step();
        write(7, 'h12, 1'b1); step();
        idle();
        got.delete();
        en = 1'b1; state_data = 'h12; step();
        en = 1'b0; step();
        check("t1_valid", 32'(out_valid), 32'd1);
        check("t1_match", 32'(match), 32'd1);
        check("t1_id", 32'(match_id), 32'd3);
        step();
        check("t1_flag", 32'(match_flag), 32'd1);
        drain();

        // Back-to-back throughput.
        got.delete();
        en = 1'b1;
        state_data = 'h05; step();
        state_data = 'h12; step();
        state_data = 'h05; step();
        drain();
        check("b2b_count", 32'(got.size()), 32'd3);
        if (got.size() == 3) begin
            check("b2b_m0", 32'(got[0].m), 32'd0);
            check("b2b_m1", 32'(got[1].m), 32'd1);
            check("b2b_m2", 32'(got[2].m), 32'd0);
        end
        check("b2b_flag", 32'(match_flag), 32'd1);

        // Stall with EN held: nothing lost or duplicated.
        got.delete();
        out_ready = 1'b0;
        en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            state_data = (i % 2 == 0) ? STATE_W'('h12) : STATE_W'('h05);
            step();
        end
        check("stall_in_ready", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        en = 1'b0;
        drain();
        check("stall_delivered", 32'(got.size()), 32'd2);

        // Same-cycle write uses old contents.
        got.delete();
        write(0, 'h40, 1'b1);
        en = 1'b1; state_data = 'h40; step();
        wr_en = 1'b0; step();
        drain();
        check("wr_same_cnt", 32'(got.size()), 32'd2);
        if (got.size() == 2) begin
            check("wr_same_m0", 32'(got[0].m), 32'd0);
            check("wr_next_m1", 32'(got[1].m), 32'd1);
            check("wr_next_id1", 32'(got[1].id), 32'd0);
        end

        // Reset with two items in flight.
        en = 1'b1; state_data = 'h12; step();
        step();
        initialize = 1'b1; step();
        idle();
        for (int i = 0; i < 3; i++) begin
            step();
            check("post_rst_valid", 32'(out_valid), 32'd0);
        end
        check("post_rst_flag", 32'(match_flag), 32'd0);
        got.delete();
        en = 1'b1; state_data = 'h12; step();
        drain();
        if (got.size() == 1) check("post_rst_nomatch", 32'(got[0].m), 32'd0);
        else check("post_rst_cnt", 32'(got.size()), 32'd1);

        // Five delivered matches (saturates a 2-bit counter).
        write(9, 'h33, 1'b1); step();
        idle();
        en = 1'b1; state_data = 'h33;
        for (int i = 0; i < 5; i++) step();
        drain();
`ifdef AHO_MATCH_COUNT_EN
        check("count_sat", 32'(match_count), 32'd3);
`else
        check("count_absent", 32'(match_count), 32'd0);
`endif

        // Randomized traffic over a small state alphabet so hits are frequent.
        for (int n = 0; n < 3000; n++) begin
            initialize = ($urandom_range(0, 199) == 0);
            en         = $urandom_range(0, 3) != 0;
            state_data = STATE_W'($urandom_range(0, 7));
            out_ready  = $urandom_range(0, 9) < 7;
            wr_en      = $urandom_range(0, 4) == 0;
            wr_addr    = ID_W'($urandom_range(0, NUM_OUT - 1));
            wr_state   = STATE_W'($urandom_range(0, 7));
            wr_valid   = $urandom_range(0, 3) != 0;
            step();
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
